diff_seq: RTL and testbench



---
 rtl/diff_seq.sv | 99 +++++++++
 tb/tb_diff_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/diff_seq.sv
// Purpose : multi-cycle KGP-RISC `diff`; returns the index of the lowest bit where rs and rt differ (WIDTH if equal).
// Latency : k+1 cycles after the accepting edge for lowest differing bit k; 1 cycle for equal operands.
// Backpr. : no queueing; start is only sampled in IDLE, so the caller must stall while busy is high.
//
// Ports:
//   clk    - clock, rising-edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled only when idle
//   rs, rt - operands, captured on the accepting edge only
//   busy   - high while a scan is in progress
//   done   - one-cycle pulse when out is updated
//   out    - result (0..WIDTH), zero-extended, held until the next completion
module diff_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  // Bit index counter; wide enough to hold WIDTH-1 with headroom.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, x_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             done_nxt;

  // State and datapath registers. Reset discards any scan in flight
  // without producing a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      cnt   <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    cnt_nxt   = cnt;
    out_nxt   = out;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          x_nxt     = rs ^ rt;
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end
      end

      SCAN: begin
        if (x == '0) begin
          // Nothing left to find: operands agree from cnt upward, and
          // everything below cnt already matched.
          out_nxt   = WIDTH'(WIDTH);
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (x[0]) begin
          out_nxt   = WIDTH'(cnt);
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          // A nonzero x always holds a set bit at or below WIDTH-1,
          // so cnt cannot run past WIDTH-1 here.
          x_nxt   = x >> 1;
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_diff_seq.sv
module tb_diff_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out;

  int n_chk  = 0;
  int n_pass = 0;

  diff_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference: lowest index where the operands differ, W when equal.
  function automatic int ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++)
      if (a[i] != b[i]) return i;
    return W;
  endfunction

  // Expected edges from the accepting edge to completion.
  function automatic int ref_lat(input int res);
    return (res == W) ? 1 : res + 1;
  endfunction

  // Called shortly after a rising edge with the DUT idle. Issues one
  // request, waits (bounded) for done and checks result and timing.
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int res, lat, bcnt;
    bit got;
    res  = ref_diff(a, b);
    lat  = 0;
    bcnt = 0;
    got  = 0;
    rs = a;
    rt = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs = $urandom;   // must not affect the running scan
    rt = $urandom;
    while (!got && lat < 64) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    chk({tag, "_timeout"}, W'(got), W'(1));
    chk({tag, "_out"}, out, W'(res));
    chk({tag, "_lat"}, W'(lat), W'(ref_lat(res)));
    chk({tag, "_busycyc"}, W'(bcnt), W'(ref_lat(res)));
    chk({tag, "_busy_at_done"}, W'(busy), W'(0));
    @(posedge clk); #1;
    chk({tag, "_done_single"}, W'(done), W'(0));
    chk({tag, "_out_held"}, out, W'(res));
  endtask

  initial begin
    logic [W-1:0] a, m;
    int lat;
    bit got;

    #1 rst = 1'b1;
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_out", out, W'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    do_req(32'd4, 32'd2, "basic");
    do_req(32'hDEADBEEF, 32'hDEADBEEF, "equal");
    do_req(32'h80000000, 32'h0, "worst");
    do_req(32'h1, 32'h0, "bit0");

    // Start held high through a scan; operands change mid-scan.
    rs = 32'h100;
    rt = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    rs = 32'h3;
    rt = 32'h0;
    lat = 0;
    got = 0;
    while (!got && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    chk("held_timeout", W'(got), W'(1));
    chk("held_out1", out, W'(8));
    chk("held_lat1", W'(lat), W'(9));
    @(posedge clk); #1;
    chk("held_busy2", W'(busy), W'(1));
    chk("held_nodone2", W'(done), W'(0));
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_done2", W'(done), W'(1));
    chk("held_out2", out, W'(0));
    @(posedge clk); #1;
    chk("held_idle", W'(busy), W'(0));
    chk("held_done_single", W'(done), W'(0));

    // Hold: result persists while idle.
    do_req(32'h20, 32'h0, "hold");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_out", out, W'(5));
      chk("hold_done", W'(done), W'(0));
    end

    // Asynchronous reset mid-scan.
    rs = 32'h80000000;
    rt = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_busy_before", W'(busy), W'(1));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", W'(busy), W'(0));
    chk("rstmid_done", W'(done), W'(0));
    chk("rstmid_out", out, W'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid_hold_done", W'(done), W'(0));
      chk("rstmid_hold_busy", W'(busy), W'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(32'd6, 32'd4, "after_rst");

    // Randomized requests; differences biased across all bit positions.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      m = $urandom;
      m = m << $urandom_range(0, W - 1);
      if ($urandom_range(0, 7) == 0) m = '0;
      do_req(a, a ^ m, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
